// File: rtl/lib_arbiter_pkg.sv
// Shared types and default sizing for the readout-path arbiters.
package lib_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_N_REQ     = 16;
    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/onehot_prio_sel.sv
// Lowest-set-bit one-hot select with binary index encode; purely combinational.
module onehot_prio_sel #(
    parameter int N = 16,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = req & (~req + {{(N-1){1'b0}}, 1'b1});
    assign any    = |req;

    // Encode the one-hot vector into its bit position.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                idx = idx | W'(i);
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/burst_rr_arbiter.sv
// Round-robin arbiter with ack handshake and bounded bursts per grant.
// Optional grant revocation on ack timeout is enabled with ARB_TIMEOUT_EN.
module burst_rr_arbiter
    import lib_arbiter_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int MAX_BURST = DEF_MAX_BURST,
`ifdef ARB_TIMEOUT_EN
    parameter int TIMEOUT   = 64,
`endif
    localparam int ADD_W    = $clog2(N_REQ)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             ack_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic             gnt_valid_o,
    output logic [ADD_W-1:0] add_o
`ifdef ARB_TIMEOUT_EN
    ,
    output logic             timeout_o
`endif
);

    localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_e       state;
    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] masked_req;
    logic [N_REQ-1:0] m_oh;
    logic [N_REQ-1:0] r_oh;
    logic [N_REQ-1:0] sel_oh;
    logic [N_REQ-1:0] new_mask;
    logic [ADD_W-1:0] m_idx;
    logic [ADD_W-1:0] r_idx;
    logic [ADD_W-1:0] sel_idx;
    logic             m_any;
    logic             r_any;
    logic             cur_req;
    logic             burst_ok;
    logic             tmo_hit;
    logic             keep;
    logic             rearb;
    logic [BC_W-1:0]  burst_cnt;

    assign masked_req = req_i & mask;

    onehot_prio_sel #(.N(N_REQ)) u_sel_masked (
        .req    (masked_req),
        .onehot (m_oh),
        .idx    (m_idx),
        .any    (m_any)
    );

    onehot_prio_sel #(.N(N_REQ)) u_sel_raw (
        .req    (req_i),
        .onehot (r_oh),
        .idx    (r_idx),
        .any    (r_any)
    );

    // Prefer requesters above the last grantee, wrap to the raw vector otherwise.
    always_comb begin
        if (m_any) begin
            sel_oh  = m_oh;
            sel_idx = m_idx;
        end else begin
            sel_oh  = r_oh;
            sel_idx = r_idx;
        end
    end

    // Next mask keeps only positions strictly above the new grantee.
    always_comb begin
        new_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i > int'(sel_idx)) begin
                new_mask[i] = 1'b1;
            end else begin
                new_mask[i] = 1'b0;
            end
        end
    end

    assign cur_req  = |(req_i & gnt_o);
    assign burst_ok = (int'(burst_cnt) + 1) < MAX_BURST;
    assign keep     = ack_i && burst_ok && cur_req;
    assign rearb    = !cur_req || (ack_i && !burst_ok) || tmo_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] tmo_cnt;

    assign tmo_hit = (state == GRANT) && !ack_i && (tmo_cnt == TO_W'(TIMEOUT - 1));

    // Ack-wait counter; a hit revokes the grant like a withdrawn request.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tmo_cnt   <= '0;
            timeout_o <= 1'b0;
        end else if (enable_i) begin
            timeout_o <= tmo_hit;
            if ((state == GRANT) && !ack_i && !rearb) begin
                tmo_cnt <= tmo_cnt + TO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Arbitration FSM; all outputs register on the same edge as the state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            mask        <= '1;
            burst_cnt   <= '0;
            gnt_o       <= '0;
            gnt_valid_o <= 1'b0;
            add_o       <= '0;
        end else if (enable_i) begin
            case (state)
                IDLE: begin
                    if (r_any) begin
                        state       <= GRANT;
                        mask        <= new_mask;
                        burst_cnt   <= '0;
                        gnt_o       <= sel_oh;
                        gnt_valid_o <= 1'b1;
                        add_o       <= sel_idx;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (rearb && r_any) begin
                        mask        <= new_mask;
                        burst_cnt   <= '0;
                        gnt_o       <= sel_oh;
                        gnt_valid_o <= 1'b1;
                        add_o       <= sel_idx;
                    end else if (rearb) begin
                        state       <= IDLE;
                        burst_cnt   <= '0;
                        gnt_o       <= '0;
                        gnt_valid_o <= 1'b0;
                        add_o       <= '0;
                    end else if (keep) begin
                        burst_cnt <= burst_cnt + BC_W'(1);
                    end else begin
                        burst_cnt <= burst_cnt;
                    end
                end
                default: begin
                    state       <= IDLE;
                    burst_cnt   <= '0;
                    gnt_o       <= '0;
                    gnt_valid_o <= 1'b0;
                    add_o       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Directed table-driven bench for burst_rr_arbiter (N_REQ=8, MAX_BURST=2, TIMEOUT=8).
module tb_burst_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       ack;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       vld;
    logic [2:0] add;
`ifdef ARB_TIMEOUT_EN
    logic       tmo;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    burst_rr_arbiter #(
        .N_REQ     (8),
        .MAX_BURST (2)
`ifdef ARB_TIMEOUT_EN
        ,
        .TIMEOUT   (8)
`endif
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .enable_i    (enable),
        .req_i       (req),
        .ack_i       (ack),
        .gnt_o       (gnt),
        .gnt_valid_o (vld),
        .add_o       (add)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout_o   (tmo)
`endif
    );

    typedef struct {
        logic       en;
        logic       ack;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] add;
        logic       vld;
    } vec_t;

    vec_t vecs[30];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] eg, input logic [2:0] ea, input logic ev);
        check({tag, " gnt"}, 32'(gnt), 32'(eg));
        check({tag, " add"}, 32'(add), 32'(ea));
        check({tag, " vld"}, 32'(vld), 32'(ev));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // en ack req -> gnt add vld, starting from grant 0 (burst 0, mask FE)
        vecs[0]  = '{1'b1, 1'b1, 8'h05, 8'h01, 3'd0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 8'h05, 8'h04, 3'd2, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 8'h05, 8'h04, 3'd2, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 8'h05, 8'h01, 3'd0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 8'h05, 8'h01, 3'd0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 8'h05, 8'h04, 3'd2, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'h81, 8'h80, 3'd7, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 8'h81, 8'h80, 3'd7, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 8'h81, 8'h01, 3'd0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 8'h81, 8'h01, 3'd0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 8'h81, 8'h80, 3'd7, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 8'h08, 8'h08, 3'd3, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 8'h08, 8'h08, 3'd3, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 8'h28, 8'h08, 3'd3, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 8'h20, 8'h20, 3'd5, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 8'h21, 8'h20, 3'd5, 1'b1};
        vecs[18] = '{1'b1, 1'b1, 8'h21, 8'h01, 3'd0, 1'b1};
        vecs[19] = '{1'b0, 1'b1, 8'hFF, 8'h01, 3'd0, 1'b1};
        vecs[20] = '{1'b0, 1'b1, 8'h00, 8'h01, 3'd0, 1'b1};
        vecs[21] = '{1'b0, 1'b1, 8'hAA, 8'h01, 3'd0, 1'b1};
        vecs[22] = '{1'b0, 1'b1, 8'h00, 8'h01, 3'd0, 1'b1};
        vecs[23] = '{1'b0, 1'b1, 8'h55, 8'h01, 3'd0, 1'b1};
        vecs[24] = '{1'b1, 1'b1, 8'h03, 8'h01, 3'd0, 1'b1};
        vecs[25] = '{1'b1, 1'b1, 8'h03, 8'h02, 3'd1, 1'b1};
        vecs[26] = '{1'b1, 1'b1, 8'h02, 8'h02, 3'd1, 1'b1};
        vecs[27] = '{1'b1, 1'b1, 8'h02, 8'h02, 3'd1, 1'b1};
        vecs[28] = '{1'b1, 1'b1, 8'h02, 8'h02, 3'd1, 1'b1};
        vecs[29] = '{1'b1, 1'b0, 8'h06, 8'h02, 3'd1, 1'b1};

        reset  = 1'b1;
        enable = 1'b1;
        ack    = 1'b0;
        req    = 8'hFF;
        #12;
        check_out("reset", 8'h00, 3'd0, 1'b0);
`ifdef ARB_TIMEOUT_EN
        check("reset tmo", 32'(tmo), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        tick();
        check_out("first", 8'h01, 3'd0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            enable = vecs[i].en;
            ack    = vecs[i].ack;
            req    = vecs[i].req;
            tick();
            check_out($sformatf("row%0d", i), vecs[i].gnt, vecs[i].add, vecs[i].vld);
        end

`ifdef ARB_TIMEOUT_EN
        // Requester 1 has seen one ack-less cycle; the eighth revokes it.
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("tmo_wait%0d gnt", k), 32'(gnt), 32'h02);
            check($sformatf("tmo_wait%0d tmo", k), 32'(tmo), 32'd0);
        end
        tick();
        check_out("tmo_hit", 8'h04, 3'd2, 1'b1);
        check("tmo_hit pulse", 32'(tmo), 32'd1);
        tick();
        check("tmo_after pulse", 32'(tmo), 32'd0);
        check("tmo_after gnt", 32'(gnt), 32'h04);
`else
        for (int k = 0; k < 100; k++) begin
            tick();
            check($sformatf("hold%0d gnt", k), 32'(gnt), 32'h02);
        end
`endif

        // Asynchronous reset mid-grant, then mask must be back to all ones.
        #2;
        reset = 1'b1;
        #1;
        check_out("async_rst", 8'h00, 3'd0, 1'b0);
        req = 8'h06;
        ack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        check_out("post_rst", 8'h02, 3'd1, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
